// File: rtl/ttt_move_planner_pkg.sv
// ttt_pkg: shared types, tables and helpers for the tic-tac-toe move planner.
//   state_t      - planner FSM states
//   game_state_t - board game_state encoding
//   LINES        - the eight winning lines as cell indices (rows, cols, diagonals)
//   CENTRE/CORNERS/SIDES - fallback move candidates in preference order
//   idx_to_row/idx_to_col - cell index 0..8 to 1-based board coordinate codes
package ttt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_PICK,
        ST_ISSUE,
        ST_WAIT,
        ST_FIN
    } state_t;

    typedef enum logic [1:0] {
        GS_RUNNING = 2'b00,
        GS_X_WON   = 2'b01,
        GS_O_WON   = 2'b10,
        GS_DRAW    = 2'b11
    } game_state_t;

    // Scan order: rows 0..2, columns 3..5, main diagonal 6, anti-diagonal 7.
    localparam logic [3:0] LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    localparam logic [3:0] CENTRE      = 4'd4;
    localparam logic [3:0] CORNERS [4] = '{4'd0, 4'd2, 4'd6, 4'd8};
    localparam logic [3:0] SIDES   [4] = '{4'd1, 4'd3, 4'd5, 4'd7};

    function automatic logic [1:0] idx_to_row(input logic [3:0] idx);
        if (idx < 4'd3)      return 2'b01;
        else if (idx < 4'd6) return 2'b10;
        else                 return 2'b11;
    endfunction

    function automatic logic [1:0] idx_to_col(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd3, 4'd6: return 2'b01;
            4'd1, 4'd4, 4'd7: return 2'b10;
            default:          return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/ttt_move_planner_if.sv
// ttt_move_planner_if: signal bundle between the planner and the board.
//   start, my_symbol                 - move request and the symbol to play
//   board_valid, board_symbol (9b)   - board occupancy and symbols, bit i = (row-1)*3+(col-1)
//   game_state (2b)                  - 00 running, 01 X won, 10 O won, 11 draw
//   set, row, col                    - one-cycle move strobe and coordinate
//   busy, done, no_move, err         - request status
// Modports: master = planner side, slave = board/requester side.
interface ttt_move_planner_if;

    logic       start;
    logic       my_symbol;
    logic [8:0] board_valid;
    logic [8:0] board_symbol;
    logic [1:0] game_state;
    logic       set;
    logic [1:0] row;
    logic [1:0] col;
    logic       busy;
    logic       done;
    logic       no_move;
    logic       err;

    modport master (
        input  start, my_symbol, board_valid, board_symbol, game_state,
        output set, row, col, busy, done, no_move, err
    );

    modport slave (
        output start, my_symbol, board_valid, board_symbol, game_state,
        input  set, row, col, busy, done, no_move, err
    );

endinterface

// File: rtl/ttt_move_planner_line_eval.sv
// ttt_line_eval: combinational evaluation of one board line.
//   cell_valid, cell_symbol (3b) - occupancy and symbol of the three cells
//   my_symbol                    - symbol the planner plays
//   win_hit                      - two of mine and one empty
//   block_hit                    - two of theirs and one empty
//   empty_pos (2b)               - position 0..2 of the lowest empty cell in the line
module ttt_line_eval (
    input  logic [2:0] cell_valid,
    input  logic [2:0] cell_symbol,
    input  logic       my_symbol,
    output logic       win_hit,
    output logic       block_hit,
    output logic [1:0] empty_pos
);

    logic [1:0] mine_cnt;
    logic [1:0] theirs_cnt;
    logic [1:0] empty_cnt;

    // Descending loop so the lowest empty position is the one left in empty_pos.
    always_comb begin
        mine_cnt   = 2'd0;
        theirs_cnt = 2'd0;
        empty_cnt  = 2'd0;
        empty_pos  = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (!cell_valid[i]) begin
                empty_cnt = empty_cnt + 2'd1;
                empty_pos = 2'(i);
            end else if (cell_symbol[i] == my_symbol) begin
                mine_cnt = mine_cnt + 2'd1;
            end else begin
                theirs_cnt = theirs_cnt + 2'd1;
            end
        end
        win_hit   = (mine_cnt == 2'd2) && (empty_cnt == 2'd1);
        block_hit = (theirs_cnt == 2'd2) && (empty_cnt == 2'd1);
    end

endmodule

// File: rtl/ttt_move_planner.sv
// ttt_move_planner: automatic tic-tac-toe opponent. On start it snapshots the
// board, scans the eight lines one per cycle, picks win > block > centre >
// corner > side, strobes the move and waits for the board to confirm it.
//   clk, reset_n - clock and asynchronous active-low reset
//   pif          - ttt_move_planner_if.master (request, board view, move strobe, status)
// Parameters: TIMEOUT (WAIT cycles before err), LFSR_SEED (random build only).
// Build option: define TTT_PLANNER_RANDOM_EN to rotate corner/side choices by a
// free-running 8-bit LFSR; otherwise choices are lowest-index and no LFSR exists.
module ttt_move_planner
    import ttt_pkg::*;
#(
    parameter int TIMEOUT = 8
`ifdef TTT_PLANNER_RANDOM_EN
    ,
    parameter logic [7:0] LFSR_SEED = 8'hA5
`endif
) (
    input logic                clk,
    input logic                reset_n,
    ttt_move_planner_if.master pif
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t         state;
    state_t         state_next;
    logic [2:0]     line_cnt;
    logic [8:0]     snap_valid;
    logic [8:0]     snap_symbol;
    logic           snap_my;
    logic           win_found;
    logic           block_found;
    logic [3:0]     win_idx;
    logic [3:0]     block_idx;
    logic [3:0]     move_idx;
    logic [3:0]     pick_idx;
    logic [WCW-1:0] wait_cnt;
    logic [2:0]     line_valid;
    logic [2:0]     line_symbol;
    logic           win_hit;
    logic           block_hit;
    logic [1:0]     empty_pos;
    logic [3:0]     empty_idx;
    logic [1:0]     rot;
    logic [1:0]     slot;
    logic           no_move_next;
    logic           err_next;
    logic           cell_taken;
    logic           cell_mine;

`ifdef TTT_PLANNER_RANDOM_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; runs continuously from reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr <= LFSR_SEED;
        else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign rot = lfsr[1:0];
`else
    assign rot = 2'd0;
`endif

    // One shared line evaluator, fed from the snapshot by the scan counter.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            line_valid[k]  = snap_valid[LINES[line_cnt][k]];
            line_symbol[k] = snap_symbol[LINES[line_cnt][k]];
        end
        empty_idx = LINES[line_cnt][empty_pos];
    end

    ttt_line_eval u_line_eval (
        .cell_valid  (line_valid),
        .cell_symbol (line_symbol),
        .my_symbol   (snap_my),
        .win_hit     (win_hit),
        .block_hit   (block_hit),
        .empty_pos   (empty_pos)
    );

    // Fallbacks: descending loops leave the first empty cell in rotated order;
    // corners are evaluated after sides so a free corner always wins.
    always_comb begin
        pick_idx = CENTRE;
        slot     = 2'd0;
        if (win_found) begin
            pick_idx = win_idx;
        end else if (block_found) begin
            pick_idx = block_idx;
        end else if (!snap_valid[CENTRE]) begin
            pick_idx = CENTRE;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                slot = 2'(k) + rot;
                if (!snap_valid[SIDES[slot]]) pick_idx = SIDES[slot];
            end
            for (int k = 3; k >= 0; k--) begin
                slot = 2'(k) + rot;
                if (!snap_valid[CORNERS[slot]]) pick_idx = CORNERS[slot];
            end
        end
    end

    assign cell_taken = pif.board_valid[move_idx];
    assign cell_mine  = (pif.board_symbol[move_idx] == snap_my);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // A cell showing the other symbol means the move was lost; fail at once.
    always_comb begin
        state_next   = state;
        no_move_next = 1'b0;
        err_next     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pif.start) begin
                    if ((pif.game_state != GS_RUNNING) || (&pif.board_valid)) begin
                        state_next   = ST_FIN;
                        no_move_next = 1'b1;
                    end else begin
                        state_next = ST_SCAN;
                    end
                end
            end
            ST_SCAN:  if (line_cnt == 3'd7) state_next = ST_PICK;
            ST_PICK:  state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (cell_taken) begin
                    state_next = ST_FIN;
                    err_next   = !cell_mine;
                end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                    state_next = ST_FIN;
                    err_next   = 1'b1;
                end
            end
            ST_FIN:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_cnt    <= 3'd0;
            snap_valid  <= 9'd0;
            snap_symbol <= 9'd0;
            snap_my     <= 1'b0;
            win_found   <= 1'b0;
            block_found <= 1'b0;
            win_idx     <= 4'd0;
            block_idx   <= 4'd0;
            move_idx    <= 4'd0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pif.start) begin
                        snap_valid  <= pif.board_valid;
                        snap_symbol <= pif.board_symbol;
                        snap_my     <= pif.my_symbol;
                        line_cnt    <= 3'd0;
                        win_found   <= 1'b0;
                        block_found <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    line_cnt <= line_cnt + 3'd1;
                    if (win_hit && !win_found) begin
                        win_found <= 1'b1;
                        win_idx   <= empty_idx;
                    end
                    if (block_hit && !block_found) begin
                        block_found <= 1'b1;
                        block_idx   <= empty_idx;
                    end
                end
                ST_PICK: begin
                    move_idx <= pick_idx;
                    wait_cnt <= '0;
                end
                ST_WAIT: wait_cnt <= wait_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so set cannot glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pif.set     <= 1'b0;
            pif.row     <= 2'b00;
            pif.col     <= 2'b00;
            pif.busy    <= 1'b0;
            pif.done    <= 1'b0;
            pif.no_move <= 1'b0;
            pif.err     <= 1'b0;
        end else begin
            pif.set     <= (state_next == ST_ISSUE);
            pif.row     <= (state_next == ST_ISSUE) ? idx_to_row(pick_idx) : 2'b00;
            pif.col     <= (state_next == ST_ISSUE) ? idx_to_col(pick_idx) : 2'b00;
            pif.busy    <= (state_next != ST_IDLE);
            pif.done    <= (state_next == ST_FIN);
            pif.no_move <= no_move_next;
            pif.err     <= err_next;
        end
    end

endmodule

// File: tb/tb_ttt_move_planner.sv
// tb_ttt_move_planner: self-checking bench for ttt_move_planner (default build).
// A vector table drives requests; expected results are queued on drive and
// popped when the planner answers. Extra sequences cover timeout, a stolen
// cell, start/board activity while busy, and reset during a scan.
module tb_ttt_move_planner;

    localparam int M_CONFIRM = 0;
    localparam int M_TIMEOUT = 1;
    localparam int M_STEAL   = 2;
    localparam int M_DISTURB = 3;
    localparam int NVEC      = 11;

    typedef struct {
        string      name;
        logic [8:0] valid;
        logic [8:0] symbol;
        logic       my;
        logic [1:0] gs;
        logic       exp_no_move;
        logic [1:0] exp_row;
        logic [1:0] exp_col;
        int         mode;
    } vec_t;

    typedef struct {
        string      name;
        logic       no_move;
        logic [1:0] row;
        logic [1:0] col;
        int         mode;
        logic       my;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    ttt_move_planner_if pif();

    ttt_move_planner dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pif     (pif)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    vec_t vecs[NVEC];
    int   checks = 0;
    int   fails  = 0;

    task automatic compare(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", what, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        pif.board_valid  = v.valid;
        pif.board_symbol = v.symbol;
        pif.my_symbol    = v.my;
        pif.game_state   = v.gs;
        pif.start        = 1'b1;
        sb.push_back('{v.name, v.exp_no_move, v.exp_row, v.exp_col, v.mode, v.my});
        @(posedge clk);
        #1;
        pif.start = 1'b0;
    endtask

    // Entered #1 after the edge that accepted start.
    task automatic checkOutput();
        exp_t e;
        int   n;
        int   idx;
        if (sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        compare({e.name, "_busy"}, pif.busy, 1);
        if (e.no_move) begin
            compare({e.name, "_done"}, pif.done, 1);
            compare({e.name, "_no_move"}, pif.no_move, 1);
            compare({e.name, "_err"}, pif.err, 0);
            compare({e.name, "_set"}, pif.set, 0);
            @(posedge clk);
            #1;
            compare({e.name, "_done_drop"}, pif.done, 0);
            compare({e.name, "_busy_drop"}, pif.busy, 0);
            compare({e.name, "_set_after"}, pif.set, 0);
        end else begin
            n = 0;
            while (pif.set !== 1'b1 && n < 30) begin
                if (e.mode == M_DISTURB && n == 3) begin
                    pif.board_valid = 9'h1FF;
                    pif.start       = 1'b1;
                end
                if (e.mode == M_DISTURB && n == 4) begin
                    pif.board_valid = 9'h000;
                    pif.start       = 1'b0;
                end
                @(posedge clk);
                #1;
                n++;
            end
            compare({e.name, "_set_latency"}, n, 9);
            compare({e.name, "_row"}, pif.row, e.row);
            compare({e.name, "_col"}, pif.col, e.col);
            idx = (int'(e.row) - 1) * 3 + (int'(e.col) - 1);
            @(posedge clk);
            #1;
            compare({e.name, "_set_pulse"}, pif.set, 0);
            compare({e.name, "_row_idle"}, pif.row, 0);
            if (e.mode == M_TIMEOUT) begin
                n = 1;
                while (pif.done !== 1'b1 && n < 30) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                compare({e.name, "_timeout_cycles"}, n, 9);
                compare({e.name, "_err"}, pif.err, 1);
            end else if (e.mode == M_STEAL) begin
                pif.board_valid[idx]  = 1'b1;
                pif.board_symbol[idx] = ~e.my;
                @(posedge clk);
                #1;
                compare({e.name, "_done"}, pif.done, 1);
                compare({e.name, "_err"}, pif.err, 1);
            end else begin
                pif.board_valid[idx]  = 1'b1;
                pif.board_symbol[idx] = e.my;
                @(posedge clk);
                #1;
                compare({e.name, "_done"}, pif.done, 1);
                compare({e.name, "_err"}, pif.err, 0);
                compare({e.name, "_no_move"}, pif.no_move, 0);
            end
            @(posedge clk);
            #1;
            compare({e.name, "_busy_drop"}, pif.busy, 0);
            compare({e.name, "_done_drop"}, pif.done, 0);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        compare({tag, "_set"}, pif.set, 0);
        compare({tag, "_row"}, pif.row, 0);
        compare({tag, "_col"}, pif.col, 0);
        compare({tag, "_busy"}, pif.busy, 0);
        compare({tag, "_done"}, pif.done, 0);
        compare({tag, "_no_move"}, pif.no_move, 0);
        compare({tag, "_err"}, pif.err, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{"empty_centre",     9'h000, 9'h000, 1'b1, 2'b00, 1'b0, 2'b10, 2'b10, M_CONFIRM};
        vecs[1]  = '{"win_x_idx2",       9'h01B, 9'h003, 1'b1, 2'b00, 1'b0, 2'b01, 2'b11, M_CONFIRM};
        vecs[2]  = '{"win_o_over_block", 9'h01B, 9'h003, 1'b0, 2'b00, 1'b0, 2'b10, 2'b11, M_CONFIRM};
        vecs[3]  = '{"block_idx2",       9'h013, 9'h003, 1'b0, 2'b00, 1'b0, 2'b01, 2'b11, M_CONFIRM};
        vecs[4]  = '{"corner_idx0",      9'h010, 9'h000, 1'b1, 2'b00, 1'b0, 2'b01, 2'b01, M_CONFIRM};
        vecs[5]  = '{"side_idx1",        9'h155, 9'h111, 1'b1, 2'b00, 1'b0, 2'b01, 2'b10, M_CONFIRM};
        vecs[6]  = '{"game_won",         9'h000, 9'h000, 1'b1, 2'b01, 1'b1, 2'b00, 2'b00, M_CONFIRM};
        vecs[7]  = '{"board_full",       9'h1FF, 9'h0AA, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, M_CONFIRM};
        vecs[8]  = '{"timeout",          9'h000, 9'h000, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10, M_TIMEOUT};
        vecs[9]  = '{"stolen_cell",      9'h010, 9'h000, 1'b1, 2'b00, 1'b0, 2'b01, 2'b01, M_STEAL};
        vecs[10] = '{"ignore_busy",      9'h000, 9'h000, 1'b1, 2'b00, 1'b0, 2'b10, 2'b10, M_DISTURB};

        pif.start        = 1'b0;
        pif.my_symbol    = 1'b0;
        pif.board_valid  = 9'h000;
        pif.board_symbol = 9'h000;
        pif.game_state   = 2'b00;
        reset_n          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Reset in the middle of a scan aborts the request.
        @(posedge clk);
        #1;
        pif.board_valid  = 9'h000;
        pif.board_symbol = 9'h000;
        pif.my_symbol    = 1'b1;
        pif.game_state   = 2'b00;
        pif.start        = 1'b1;
        @(posedge clk);
        #1;
        pif.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare("mid_scan_busy", pif.busy, 1);
        reset_n = 1'b0;
        #1;
        checkIdleOutputs("abort");
        @(posedge clk);
        #1;
        compare("abort_hold_busy", pif.busy, 0);
        reset_n = 1'b1;

        applyStimulus(vecs[0]);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
